// File: rtl/mp_wb_pkg.sv
// Shared types and constants for the mp_wb writeback stage.
// Holds the buffered-entry layout, the default geometry and the split-phase encoding.
package mp_wb_pkg;

    localparam int AW_DEF       = 4;
    localparam bit ZERO_REG_DEF = 1'b1;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    typedef struct packed {
        logic [31:0]       data;
        logic [AW_DEF-1:0] rd;
        logic              wide;
    } wb_entry_t;

endpackage

// File: rtl/mp_wb_fifo2.sv
// Two-entry result buffer for the writeback stage (module wb_fifo2).
// Exposes the head entry plus the destination of the entry queued behind it.
module wb_fifo2
    import mp_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  wb_entry_t         push_data,
    output wb_entry_t         head,
    output logic [AW_DEF-1:0] second_rd,
    output logic              second_wide,
    output logic [1:0]        cnt
);

    wb_entry_t mem [2];
    logic      rptr;
    logic      wptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            rptr <= 1'b0;
            wptr <= 1'b0;
        end else if (clear) begin
            cnt  <= 2'd0;
            rptr <= 1'b0;
            wptr <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: cnt alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head        = mem[rptr];
    assign second_rd   = mem[~rptr].rd;
    assign second_wide = mem[~rptr].wide;

endmodule

// File: rtl/mp_wb.sv
// Writeback stage: buffers execute results and serialises them onto a 16-bit
// register-file write port, splitting wide results into low/high writes.
//
//   phase | meaning
//   PH_LO | head is narrow, or wide with its low half still to write
//   PH_HI | wide head's low half done; high half writes next
module mp_wb
    import mp_wb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [31:0]         in_data,
    input  logic [AW-1:0]       in_rd,
    input  logic                in_wide,
    input  logic                in_wen,
    input  logic                flush,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [15:0]         rf_wdata,
    output logic                busy,
    output logic [(1<<AW)-1:0]  pend
);

    wb_entry_t     head;
    wb_entry_t     push_data;
    logic [AW-1:0] second_rd;
    logic          second_wide;
    logic [1:0]    cnt;
    phase_t        phase;
    logic          push;
    logic          pop;
    logic          advance;
    logic [AW-1:0] waddr;

    function automatic logic [(1<<AW)-1:0] dest_bits(input logic [AW-1:0] rd,
                                                     input logic wide,
                                                     input logic lo_left);
        logic [(1<<AW)-1:0] b;
        b = '0;
        if (wide) begin
            if (lo_left && !(ZERO_REG && rd[AW-1:1] == '0))
                b[{rd[AW-1:1], 1'b0}] = 1'b1;
            b[{rd[AW-1:1], 1'b1}] = 1'b1;
        end else begin
            b[rd] = 1'b1;
        end
        return b;
    endfunction

    assign in_rdy    = (cnt != 2'd2) && !flush;
    assign push      = in_vld && in_rdy && in_wen && !(ZERO_REG && !in_wide && in_rd == '0);
    assign push_data = '{data: in_data, rd: in_rd, wide: in_wide};
    assign busy      = (cnt != 2'd0);
    assign advance   = busy && !flush;
    assign pop       = advance && (!head.wide || phase == PH_HI);

    wb_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .clear       (flush),
        .push_data   (push_data),
        .head        (head),
        .second_rd   (second_rd),
        .second_wide (second_wide),
        .cnt         (cnt)
    );

    always_comb begin
        waddr = head.rd;
        if (head.wide) waddr = {head.rd[AW-1:1], phase == PH_HI};
    end

    assign rf_waddr = waddr;
    assign rf_wdata = (head.wide && phase == PH_HI) ? head.data[31:16] : head.data[15:0];
    // A suppressed r0 write still spends its cycle so the high half follows in order.
    assign rf_we    = advance && !(ZERO_REG && waddr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_LO;
        end else if (flush) begin
            phase <= PH_LO;
        end else if (advance && head.wide) begin
            phase <= (phase == PH_LO) ? PH_HI : PH_LO;
        end
    end

    always_comb begin
        pend = '0;
        if (cnt != 2'd0) pend = pend | dest_bits(head.rd, head.wide, phase == PH_LO);
        if (cnt == 2'd2) pend = pend | dest_bits(second_rd, second_wide, 1'b1);
    end

endmodule

// File: tb/tb_mp_wb.sv
// Directed self-checking bench for mp_wb: per-cycle hand-computed expectations
// for reset, narrow streaming, wide splitting, suppression, flush and full buffer.
module tb_mp_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic [3:0]  in_rd;
    logic        in_wide;
    logic        in_wen;
    logic        flush;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic [15:0] pend;

    int n_cmp = 0;
    int n_mis = 0;

    mp_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_rd    (in_rd),
        .in_wide  (in_wide),
        .in_wen   (in_wen),
        .flush    (flush),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Drive inputs for the coming edge, then let combinational outputs settle.
    task automatic step(input logic vld, input logic [31:0] d, input logic [3:0] rd,
                        input logic wide, input logic wen, input logic fl);
        @(negedge clk);
        in_vld  = vld;
        in_data = d;
        in_rd   = rd;
        in_wide = wide;
        in_wen  = wen;
        flush   = fl;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_wr(input string tag, input logic [3:0] a, input logic [15:0] d);
        chk({tag, ".we"}, {31'b0, rf_we}, 32'd1);
        chk({tag, ".addr"}, {28'b0, rf_waddr}, {28'b0, a});
        chk({tag, ".data"}, {16'b0, rf_wdata}, {16'b0, d});
    endtask

    task automatic exp_st(input string tag, input logic we, input logic rdy,
                          input logic bsy, input logic [15:0] pd);
        chk({tag, ".we"}, {31'b0, rf_we}, {31'b0, we});
        chk({tag, ".rdy"}, {31'b0, in_rdy}, {31'b0, rdy});
        chk({tag, ".busy"}, {31'b0, busy}, {31'b0, bsy});
        chk({tag, ".pend"}, {16'b0, pend}, {16'b0, pd});
    endtask

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_rd = '0;
        in_wide = 1'b0; in_wen = 1'b0; flush = 1'b0;
        #3;
        exp_st("rst", 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Narrow back-to-back
        step(1'b1, 32'h0000ABCD, 4'd3, 1'b0, 1'b1, 1'b0);
        exp_st("nb0", 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 32'h00001234, 4'd5, 1'b0, 1'b1, 1'b0);
        exp_st("nb1", 1'b1, 1'b1, 1'b1, 16'h0008);
        exp_wr("nb1", 4'd3, 16'hABCD);
        idle();
        exp_st("nb2", 1'b1, 1'b1, 1'b1, 16'h0020);
        exp_wr("nb2", 4'd5, 16'h1234);
        chk("nb2.pend3", {31'b0, pend[3]}, 32'd0);
        idle();
        exp_st("nb3", 1'b0, 1'b1, 1'b0, 16'h0000);

        // Wide split with backpressure; third result held while the buffer is full
        step(1'b1, 32'h12345678, 4'd7, 1'b1, 1'b1, 1'b0);
        exp_st("w0", 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 32'hDEADBEEF, 4'd4, 1'b1, 1'b1, 1'b0);
        exp_st("w1", 1'b1, 1'b1, 1'b1, 16'h00C0);
        exp_wr("w1", 4'd6, 16'h5678);
        step(1'b1, 32'h0F0F0F0F, 4'd2, 1'b1, 1'b1, 1'b0);
        exp_st("w2", 1'b1, 1'b0, 1'b1, 16'h00B0);
        exp_wr("w2", 4'd7, 16'h1234);
        step(1'b1, 32'h0F0F0F0F, 4'd2, 1'b1, 1'b1, 1'b0);
        exp_st("w3", 1'b1, 1'b1, 1'b1, 16'h0030);
        exp_wr("w3", 4'd4, 16'hBEEF);
        idle();
        exp_st("w4", 1'b1, 1'b0, 1'b1, 16'h002C);
        exp_wr("w4", 4'd5, 16'hDEAD);
        idle();
        exp_st("w5", 1'b1, 1'b1, 1'b1, 16'h000C);
        exp_wr("w5", 4'd2, 16'h0F0F);
        idle();
        exp_st("w6", 1'b1, 1'b1, 1'b1, 16'h0008);
        exp_wr("w6", 4'd3, 16'h0F0F);
        idle();
        exp_st("w7", 1'b0, 1'b1, 1'b0, 16'h0000);

        // Suppression: no-write retire, narrow r0, wide pair starting at r0
        step(1'b1, 32'h00001111, 4'd9, 1'b0, 1'b0, 1'b0);
        exp_st("s0", 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 32'h00002222, 4'd0, 1'b0, 1'b1, 1'b0);
        exp_st("s1", 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 32'hAAAA5555, 4'd1, 1'b1, 1'b1, 1'b0);
        exp_st("s2", 1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        exp_st("s3", 1'b0, 1'b1, 1'b1, 16'h0002);
        idle();
        exp_st("s4", 1'b1, 1'b1, 1'b1, 16'h0002);
        exp_wr("s4", 4'd1, 16'hAAAA);
        idle();
        exp_st("s5", 1'b0, 1'b1, 1'b0, 16'h0000);

        // Flush with two entries after the wide low half committed
        step(1'b1, 32'h99998888, 4'd8, 1'b1, 1'b1, 1'b0);
        exp_st("f0", 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 32'h00007777, 4'd10, 1'b0, 1'b1, 1'b0);
        exp_st("f1", 1'b1, 1'b1, 1'b1, 16'h0300);
        exp_wr("f1", 4'd8, 16'h8888);
        step(1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        exp_st("f2", 1'b0, 1'b0, 1'b1, 16'h0600);
        idle();
        exp_st("f3", 1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        exp_st("f4", 1'b0, 1'b1, 1'b0, 16'h0000);

        // Asynchronous reset in the middle of a wide write
        step(1'b1, 32'h5A5AC3C3, 4'd12, 1'b1, 1'b1, 1'b0);
        exp_st("r0", 1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        exp_wr("r1", 4'd12, 16'hC3C3);
        idle();
        exp_wr("r2", 4'd13, 16'h5A5A);
        #1 rst_n = 1'b0;
        #1;
        exp_st("r2rst", 1'b0, 1'b1, 1'b0, 16'h0000);
        #1 rst_n = 1'b1;
        idle();
        exp_st("r3", 1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        exp_st("r4", 1'b0, 1'b1, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
